ex2mem_pipe_reg: RTL and testbench
==================================

// Module: ex2mem_pipe_reg
// PURPOSE
//  EX->MEM pipeline register. Captures EX-stage results each cycle and drives the Ex2Mem
//  operands consumed by the forwarding unit and the MEM stage. Detects load-use hazards
//  against the instruction in EX. Enforces hold (stall), bubble and flush priorities.
// PARAMETERS
//  DATA_W   64  data/ALU result width
//  PC_W     64  program counter width
//  RADDR_W  5   register-file address width
//  CNT_W    32  width of the hazard-bubble counter (saturating)
// PORTS
//  Clk                     in   1        clock, rising edge
//  RstN                    in   1        asynchronous reset, active low
//  ValidExIn               in   1        EX holds a real instruction
//  PcExIn                  in   PC_W     PC of EX instruction
//  AluResultExIn           in   DATA_W   ALU result / effective address
//  StoreDataExIn           in   DATA_W   forwarded rs2 data for stores
//  RdAddrExIn              in   RADDR_W  destination register
//  RdWriteEnableExIn       in   1        EX instruction writes rd
//  MemReadExIn             in   1        EX instruction is a load
//  MemWriteExIn            in   1        EX instruction is a store
//  MemSizeExIn             in   3        funct3 size/sign code
//  Rs1AddrExIn/Rs2AddrExIn in   RADDR_W  source registers of EX instruction
//  StallIn                 in   1        MEM stage busy: hold all state
//  FlushIn                 in   1        redirect: kill captured instruction
//  ValidEx2MemOut          out  1        register holds a real instruction
//  PcEx2MemOut             out  PC_W     registered PC
//  RdWriteDataEx2MemOut    out  DATA_W   registered ALU result
//  StoreDataEx2MemOut      out  DATA_W   registered store data
//  RdAddrEx2MemOut         out  RADDR_W  registered rd
//  RdWriteEnableEx2MemOut  out  1        forwardable write: valid & wen & rd!=0 & !load
//  MemReadEx2MemOut/MemWriteEx2MemOut out 1  registered, gated by valid
//  MemSizeEx2MemOut        out  3        registered size code
//  LoadUseHazardOut        out  1        comb: EX must hold one cycle
//  StallUpstreamOut        out  1        comb: StallIn | LoadUseHazardOut
//  BubbleCountOut          out  CNT_W    count of inserted hazard bubbles
// BEHAVIOUR
//  Reset (async, RstN=0): every registered output is 0, the counter is 0 and
//   Valid=0. Combinational outputs follow from the zeroed state.
//  Per-edge priority: FlushIn > StallIn > LoadUseHazard > capture.
//   Flush: Valid<=0, MemRead<=0, MemWrite<=0, RdWriteEnable<=0. Data fields
//    don't-care; they are held.
//   Stall: all registers hold. The counter holds.
//   Hazard: insert a bubble (Valid<=0, enables 0). BubbleCount<=min(count+1, 2^CNT_W-1).
//   Capture: all fields <= EX inputs. Valid<=ValidExIn. Enables are ANDed with ValidExIn.
//  LoadUseHazardOut = ValidEx2Mem & MemReadEx2Mem & ValidExIn & RdAddrEx2Mem!=0 &
//   (RdAddrEx2Mem==Rs1AddrExIn | RdAddrEx2Mem==Rs2AddrExIn).
//   It is asserted while StallIn=1 but has no effect on state.
//  Load in register: RdWriteEnableEx2MemOut=0, so forwarding never selects unready data.
//  Latency: 1 cycle from EX inputs to outputs. No combinational path from EX data to outputs.
//  Back-to-back loads: each dependent consumer causes exactly 1 bubble.
//  Flush together with hazard: flush wins. The counter does not increment.
//  Counter saturates at all-ones and never wraps.
// STRUCTURE
//  Shared defines: DataBus, RegFileAddr, and the MemSize encodings (LB..LWU/LD).
//  No sub-module. Single always block for registers, plus assigns for hazard and gating.
// TESTING
//  1. Reset mid-run: assert RstN=0 with Valid=1 -> all outputs 0 immediately, before any clock edge.
//  2. Capture: ALU=64'h1234, rd=5, wen=1 -> next cycle RdWriteData=64'h1234, RdAddr=5, RdWriteEnable=1.
//  3. Load-use: ld x5, then EX rs1=5 -> LoadUseHazard=1, one bubble (Valid=0), BubbleCount=1.
//     Next cycle EX instruction captured.
//  4. rd=x0 load plus consumer rs1=0 -> no hazard. Write to x0 -> RdWriteEnableEx2MemOut=0.
//  5. StallIn=1 for 3 cycles with new EX data -> outputs unchanged. Release -> new data 1 cycle later.
//  6. FlushIn together with hazard and StallIn -> Valid=0 next cycle, count unchanged.
//     Counter preset near all-ones -> saturates, no wrap.

Source files
------------

// File: rtl/ex2mem_pipe_reg_pkg.sv
// Shared definitions for the EX->MEM pipeline register: default widths,
// bus typedefs and the funct3 memory size/sign encodings.
package ex2mem_pipe_reg_pkg;

    localparam int DATA_W_DEF  = 64;
    localparam int PC_W_DEF    = 64;
    localparam int RADDR_W_DEF = 5;
    localparam int CNT_W_DEF   = 32;
    localparam int MEM_SIZE_W  = 3;

    typedef logic [DATA_W_DEF-1:0]  data_bus_t;
    typedef logic [RADDR_W_DEF-1:0] reg_file_addr_t;

    // funct3 codes for loads/stores; bit 2 selects zero-extension on loads
    typedef enum logic [MEM_SIZE_W-1:0] {
        MEM_LB  = 3'b000,
        MEM_LH  = 3'b001,
        MEM_LW  = 3'b010,
        MEM_LD  = 3'b011,
        MEM_LBU = 3'b100,
        MEM_LHU = 3'b101,
        MEM_LWU = 3'b110
    } mem_size_e;

endpackage

// File: rtl/ex2mem_pipe_reg.sv
// EX->MEM pipeline register with load-use hazard detection, bubble insertion
// and a saturating count of inserted hazard bubbles.
module ex2mem_pipe_reg
    import ex2mem_pipe_reg_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PC_W    = PC_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                  Clk,
    input  logic                  RstN,
    input  logic                  ValidExIn,
    input  logic [PC_W-1:0]       PcExIn,
    input  logic [DATA_W-1:0]     AluResultExIn,
    input  logic [DATA_W-1:0]     StoreDataExIn,
    input  logic [RADDR_W-1:0]    RdAddrExIn,
    input  logic                  RdWriteEnableExIn,
    input  logic                  MemReadExIn,
    input  logic                  MemWriteExIn,
    input  logic [MEM_SIZE_W-1:0] MemSizeExIn,
    input  logic [RADDR_W-1:0]    Rs1AddrExIn,
    input  logic [RADDR_W-1:0]    Rs2AddrExIn,
    input  logic                  StallIn,
    input  logic                  FlushIn,
    output logic                  ValidEx2MemOut,
    output logic [PC_W-1:0]       PcEx2MemOut,
    output logic [DATA_W-1:0]     RdWriteDataEx2MemOut,
    output logic [DATA_W-1:0]     StoreDataEx2MemOut,
    output logic [RADDR_W-1:0]    RdAddrEx2MemOut,
    output logic                  RdWriteEnableEx2MemOut,
    output logic                  MemReadEx2MemOut,
    output logic                  MemWriteEx2MemOut,
    output logic [MEM_SIZE_W-1:0] MemSizeEx2MemOut,
    output logic                  LoadUseHazardOut,
    output logic                  StallUpstreamOut,
    output logic [CNT_W-1:0]      BubbleCountOut
);

    logic                  valid_q, valid_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [DATA_W-1:0]     alu_q, alu_d;
    logic [DATA_W-1:0]     store_q, store_d;
    logic [RADDR_W-1:0]    rd_q, rd_d;
    logic                  wen_q, wen_d;
    logic                  mrd_q, mrd_d;
    logic                  mwr_q, mwr_d;
    logic [MEM_SIZE_W-1:0] size_q, size_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic rd_nonzero;
    logic rs_match;
    logic load_use_hazard;

    assign rd_nonzero      = (rd_q != '0);
    assign rs_match        = (rd_q == Rs1AddrExIn) || (rd_q == Rs2AddrExIn);
    assign load_use_hazard = valid_q & mrd_q & ValidExIn & rd_nonzero & rs_match;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        alu_d   = alu_q;
        store_d = store_q;
        rd_d    = rd_q;
        wen_d   = wen_q;
        mrd_d   = mrd_q;
        mwr_d   = mwr_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        if (FlushIn) begin
            valid_d = 1'b0;
            wen_d   = 1'b0;
            mrd_d   = 1'b0;
            mwr_d   = 1'b0;
        end else if (!StallIn) begin
            if (load_use_hazard) begin
                // bubble: data fields held, only the control bits are cleared
                valid_d = 1'b0;
                wen_d   = 1'b0;
                mrd_d   = 1'b0;
                mwr_d   = 1'b0;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                valid_d = ValidExIn;
                pc_d    = PcExIn;
                alu_d   = AluResultExIn;
                store_d = StoreDataExIn;
                rd_d    = RdAddrExIn;
                wen_d   = RdWriteEnableExIn & ValidExIn;
                mrd_d   = MemReadExIn & ValidExIn;
                mwr_d   = MemWriteExIn & ValidExIn;
                size_d  = MemSizeExIn;
            end
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            alu_q   <= '0;
            store_q <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            size_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            alu_q   <= alu_d;
            store_q <= store_d;
            rd_q    <= rd_d;
            wen_q   <= wen_d;
            mrd_q   <= mrd_d;
            mwr_q   <= mwr_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
        end
    end

    // a load's result is not ready in MEM, so it is never offered for forwarding
    assign RdWriteEnableEx2MemOut = valid_q & wen_q & rd_nonzero & ~mrd_q;
    assign ValidEx2MemOut         = valid_q;
    assign PcEx2MemOut            = pc_q;
    assign RdWriteDataEx2MemOut   = alu_q;
    assign StoreDataEx2MemOut     = store_q;
    assign RdAddrEx2MemOut        = rd_q;
    assign MemReadEx2MemOut       = valid_q & mrd_q;
    assign MemWriteEx2MemOut      = valid_q & mwr_q;
    assign MemSizeEx2MemOut       = size_q;
    assign LoadUseHazardOut       = load_use_hazard;
    assign StallUpstreamOut       = StallIn | load_use_hazard;
    assign BubbleCountOut         = cnt_q;

endmodule

// File: tb/tb_ex2mem_pipe_reg.sv
// Randomized and directed bench for ex2mem_pipe_reg against a behavioural
// model of the MEM-stage slot; the counter is narrowed so saturation is reachable.
module tb_ex2mem_pipe_reg;

    localparam int DW   = 64;
    localparam int PW   = 64;
    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          RstN;
    logic          ValidExIn;
    logic [PW-1:0] PcExIn;
    logic [DW-1:0] AluResultExIn;
    logic [DW-1:0] StoreDataExIn;
    logic [AW-1:0] RdAddrExIn;
    logic          RdWriteEnableExIn;
    logic          MemReadExIn;
    logic          MemWriteExIn;
    logic [2:0]    MemSizeExIn;
    logic [AW-1:0] Rs1AddrExIn;
    logic [AW-1:0] Rs2AddrExIn;
    logic          StallIn;
    logic          FlushIn;
    logic          ValidEx2MemOut;
    logic [PW-1:0] PcEx2MemOut;
    logic [DW-1:0] RdWriteDataEx2MemOut;
    logic [DW-1:0] StoreDataEx2MemOut;
    logic [AW-1:0] RdAddrEx2MemOut;
    logic          RdWriteEnableEx2MemOut;
    logic          MemReadEx2MemOut;
    logic          MemWriteEx2MemOut;
    logic [2:0]    MemSizeEx2MemOut;
    logic          LoadUseHazardOut;
    logic          StallUpstreamOut;
    logic [CW-1:0] BubbleCountOut;

    ex2mem_pipe_reg #(.DATA_W(DW), .PC_W(PW), .RADDR_W(AW), .CNT_W(CW)) dut (
        .Clk(Clk), .RstN(RstN),
        .ValidExIn(ValidExIn), .PcExIn(PcExIn), .AluResultExIn(AluResultExIn),
        .StoreDataExIn(StoreDataExIn), .RdAddrExIn(RdAddrExIn),
        .RdWriteEnableExIn(RdWriteEnableExIn), .MemReadExIn(MemReadExIn),
        .MemWriteExIn(MemWriteExIn), .MemSizeExIn(MemSizeExIn),
        .Rs1AddrExIn(Rs1AddrExIn), .Rs2AddrExIn(Rs2AddrExIn),
        .StallIn(StallIn), .FlushIn(FlushIn),
        .ValidEx2MemOut(ValidEx2MemOut), .PcEx2MemOut(PcEx2MemOut),
        .RdWriteDataEx2MemOut(RdWriteDataEx2MemOut),
        .StoreDataEx2MemOut(StoreDataEx2MemOut), .RdAddrEx2MemOut(RdAddrEx2MemOut),
        .RdWriteEnableEx2MemOut(RdWriteEnableEx2MemOut),
        .MemReadEx2MemOut(MemReadEx2MemOut), .MemWriteEx2MemOut(MemWriteEx2MemOut),
        .MemSizeEx2MemOut(MemSizeEx2MemOut), .LoadUseHazardOut(LoadUseHazardOut),
        .StallUpstreamOut(StallUpstreamOut), .BubbleCountOut(BubbleCountOut)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];

    // what the MEM-stage slot should contain, as the pipeline sees it
    typedef struct {
        bit        valid;
        bit [63:0] pc;
        bit [63:0] alu;
        bit [63:0] sd;
        int        rd;
        bit        wen;
        bit        is_load;
        bit        is_store;
        int        size;
    } slot_t;

    slot_t slot;
    int    bubbles;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_hazard();
        int rs1 = int'(Rs1AddrExIn);
        int rs2 = int'(Rs2AddrExIn);
        return slot.valid && slot.is_load && ValidExIn && slot.rd != 0 &&
               (slot.rd == rs1 || slot.rd == rs2);
    endfunction

    function automatic void model_reset();
        slot    = '{default: 0};
        bubbles = 0;
    endfunction

    // one clock edge worth of pipeline behaviour
    function automatic void model_edge();
        if (FlushIn) begin
            slot.valid = 0; slot.wen = 0; slot.is_load = 0; slot.is_store = 0;
        end else if (StallIn) begin
            // everything frozen
        end else if (model_hazard()) begin
            slot.valid = 0; slot.wen = 0; slot.is_load = 0; slot.is_store = 0;
            bubbles = (bubbles + 1 > CMAX) ? CMAX : bubbles + 1;
        end else begin
            slot.valid    = ValidExIn;
            slot.pc       = PcExIn;
            slot.alu      = AluResultExIn;
            slot.sd       = StoreDataExIn;
            slot.rd       = int'(RdAddrExIn);
            slot.wen      = RdWriteEnableExIn && ValidExIn;
            slot.is_load  = MemReadExIn && ValidExIn;
            slot.is_store = MemWriteExIn && ValidExIn;
            slot.size     = int'(MemSizeExIn);
        end
    endfunction

    task automatic check_regs();
        bit fwd;
        fwd = slot.valid && slot.wen && slot.rd != 0 && !slot.is_load;
        exp_q.push_back(slot.alu);
        check("valid",   ValidEx2MemOut,         slot.valid);
        check("pc",      PcEx2MemOut,            slot.pc);
        check("rd_data", RdWriteDataEx2MemOut,   exp_q.pop_front());
        check("st_data", StoreDataEx2MemOut,     slot.sd);
        check("rd_addr", RdAddrEx2MemOut,        64'(slot.rd));
        check("rd_wen",  RdWriteEnableEx2MemOut, fwd);
        check("mem_rd",  MemReadEx2MemOut,       slot.valid && slot.is_load);
        check("mem_wr",  MemWriteEx2MemOut,      slot.valid && slot.is_store);
        check("size",    MemSizeEx2MemOut,       64'(slot.size));
        check("bubbles", BubbleCountOut,         64'(bubbles));
    endtask

    // inputs are set just after a falling edge; comb checked, then one edge
    task automatic step();
        #1;
        check("hazard",   LoadUseHazardOut, model_hazard());
        check("stall_up", StallUpstreamOut, StallIn || model_hazard());
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        check_regs();
    endtask

    // driver tasks
    task automatic set_ex(input bit v, input logic [63:0] pc, input logic [63:0] alu,
                          input logic [63:0] sd, input int rd, input bit wen,
                          input bit mr, input bit mw, input int sz,
                          input int rs1, input int rs2);
        ValidExIn         = v;
        PcExIn            = pc;
        AluResultExIn     = alu;
        StoreDataExIn     = sd;
        RdAddrExIn        = AW'(rd);
        RdWriteEnableExIn = wen;
        MemReadExIn       = mr;
        MemWriteExIn      = mw;
        MemSizeExIn       = 3'(sz);
        Rs1AddrExIn       = AW'(rs1);
        Rs2AddrExIn       = AW'(rs2);
    endtask

    task automatic set_ctl(input bit stall, input bit flush);
        StallIn = stall;
        FlushIn = flush;
    endtask

    task automatic rand_ex();
        bit ld, st;
        ld = ($urandom_range(0, 9) < 3);
        st = !ld && ($urandom_range(0, 4) == 0);
        set_ex($urandom_range(0, 9) != 0,
               {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
               $urandom_range(0, 7), $urandom_range(0, 1), ld, st,
               $urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 7));
        set_ctl($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5);
    endtask

    initial begin
        int cnt_before;
        RstN = 1'b0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 0);
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        check_regs();
        check("rst_hazard", LoadUseHazardOut, 1'b0);
        RstN = 1'b1;

        // plain capture
        set_ex(1, 64'h100, 64'h1234, 64'hdead, 5, 1, 0, 0, 3, 1, 2);
        step();
        check("cap_alu", RdWriteDataEx2MemOut, 64'h1234);
        check("cap_rd",  RdAddrEx2MemOut, 64'd5);
        check("cap_wen", RdWriteEnableEx2MemOut, 1'b1);

        // load x5 followed by a consumer of x5
        set_ex(1, 64'h104, 64'h8000, 0, 5, 1, 1, 0, 3, 1, 2);
        step();
        check("ld_fwd_off", RdWriteEnableEx2MemOut, 1'b0);
        set_ex(1, 64'h108, 64'h77, 0, 6, 1, 0, 0, 0, 5, 9);
        #1;
        check("lu_hazard", LoadUseHazardOut, 1'b1);
        step();
        check("lu_bubble", ValidEx2MemOut, 1'b0);
        check("lu_count",  BubbleCountOut, 64'd1);
        step();
        check("lu_capture", PcEx2MemOut, 64'h108);
        check("lu_valid",   ValidEx2MemOut, 1'b1);

        // load to x0 never creates a hazard; writes to x0 are not forwardable
        set_ex(1, 64'h10c, 64'h10, 0, 0, 1, 1, 0, 2, 1, 1);
        step();
        set_ex(1, 64'h110, 64'h20, 0, 0, 1, 0, 0, 0, 0, 0);
        #1;
        check("x0_hazard", LoadUseHazardOut, 1'b0);
        step();
        check("x0_wen", RdWriteEnableEx2MemOut, 1'b0);

        // stall for three cycles while EX keeps changing
        set_ex(1, 64'h200, 64'haaaa, 64'h1, 7, 1, 0, 0, 1, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_ex(1, 64'h300 + 64'(i), 64'hbbbb + 64'(i), 64'h2, 8, 1, 0, 1, 2, 0, 0);
            set_ctl(1, 0);
            step();
            check("stall_hold", RdWriteDataEx2MemOut, 64'haaaa);
        end
        set_ctl(0, 0);
        step();
        check("stall_release", RdWriteDataEx2MemOut, 64'hbbbd);

        // flush beats stall and hazard together
        set_ex(1, 64'h400, 64'h40, 0, 6, 1, 1, 0, 3, 0, 0);
        step();
        cnt_before = bubbles;
        set_ex(1, 64'h404, 64'h44, 0, 9, 1, 0, 0, 0, 6, 0);
        set_ctl(1, 1);
        #1;
        check("fl_hazard_seen", LoadUseHazardOut, 1'b1);
        step();
        check("fl_valid", ValidEx2MemOut, 1'b0);
        check("fl_count", BubbleCountOut, 64'(cnt_before));
        set_ctl(0, 0);

        // drive the counter into saturation
        for (int i = 0; i < CMAX + 4; i++) begin
            set_ex(1, 64'h500, 64'h50, 0, 3, 1, 1, 0, 3, 0, 0);
            step();
            set_ex(1, 64'h504, 64'h54, 0, 4, 1, 0, 0, 0, 1, 3);
            step();
            step();
        end
        check("sat_count", BubbleCountOut, 64'(CMAX));

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            rand_ex();
            step();
        end

        // asynchronous reset while a real instruction is held
        set_ctl(0, 0);
        set_ex(1, 64'h600, 64'h66, 64'h6, 9, 1, 1, 1, 3, 0, 0);
        step();
        RstN = 1'b0;
        #1;
        model_reset();
        check("arst_valid", ValidEx2MemOut, 1'b0);
        check("arst_data",  RdWriteDataEx2MemOut, 64'd0);
        check("arst_count", BubbleCountOut, 64'd0);
        check_regs();
        @(negedge Clk);
        RstN = 1'b1;

        for (int i = 0; i < 100; i++) begin
            rand_ex();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
